apb_gpi_slave: RTL and testbench
================================

APB_GPI_SLAVE -- requirements
Module: apb_gpi_slave

Interface
REQ-001 Parameter GPIO_WIDTH, default 8, number of GPIO input pins (legal 1..32).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 PSEL  input  1  APB slave select.
REQ-005 PENABLE  input  1  APB access phase.
REQ-006 PWRITE  input  1  1 = write, 0 = read.
REQ-007 PADDR  input  8  byte address within the slave window.
REQ-008 PWDATA  input  32  write data.
REQ-009 PRDATA  output  32  read data; valid only while PREADY=1.
REQ-010 PREADY  output  1  transfer completion.
REQ-011 PSLVERR  output  1  error response; valid only while PREADY=1.
REQ-012 gpi  input  GPIO_WIDTH  asynchronous external input pins.
REQ-013 irq  output  1  level interrupt request.

Function
REQ-014 The slave SHALL use FSM states IDLE, ACCESS and READY, with exactly one wait state per transfer.
REQ-015 IDLE: PSEL=1 and PENABLE=0 -> latch PADDR, PWRITE and PWDATA; go to ACCESS.
REQ-016 ACCESS: PREADY=0; decode the latched address; register read data and error flag; go to READY. PSEL=0 here -> IDLE, no register effect.
REQ-017 READY: PREADY=1, PRDATA and PSLVERR driven from registers; a write commits on the edge leaving READY; next state IDLE.
REQ-018 Register map (PADDR[7:2] word index): 0x00 IDR RO synchronized pins; 0x04 IER RW interrupt enable; 0x08 RISE W1C rising-edge status; 0x0C FALL W1C falling-edge status.
REQ-019 Bits above GPIO_WIDTH SHALL read 0 and ignore writes.
REQ-020 PADDR >= 0x10 or PADDR[1:0] != 0 SHALL give PSLVERR=1 and PRDATA=0, with no register change.
REQ-021 Writes to IDR SHALL be ignored with PSLVERR=0.
REQ-022 gpi SHALL pass through a 2-flop synchronizer; IDR reflects a pin change after 2 rising edges.
REQ-023 Edge detect SHALL compare the synchronized value with its one-cycle-delayed copy.
REQ-024 The matching RISE/FALL bit SHALL set on the 3rd edge after the pin change and stay set until cleared.
REQ-025 Writing 1 to a RISE/FALL bit SHALL clear it; writing 0 SHALL leave it unchanged.
REQ-026 If an edge set and a W1C clear hit the same bit in the same cycle, set SHALL win.
REQ-027 irq = OR over ((RISE | FALL) & IER); combinational from registers, with no added latency.
REQ-028 Back-to-back transfers: a new SETUP phase is accepted in the cycle immediately after READY (IDLE).

Reset
REQ-029 While reset=0: FSM=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, IER=0, RISE=0, FALL=0, synchronizer and delay flops=0, irq=0.
REQ-030 Reset asserted mid-transfer SHALL abort it with no register write; the slave restarts in IDLE after release.
REQ-031 Synchronizer flops reset to 0; a pin held high through reset therefore SHALL set RISE 3 edges after release.

Structure
REQ-032 Package apb_gpi_pkg SHALL hold the register offset constants (0x00/0x04/0x08/0x0C) and the FSM state enum.
REQ-033 Sub-module gpi_sync_edge (per-vector 2-flop synchronizer plus delay flop; outputs sync, rise, fall) SHALL be instantiated once.

Verification
REQ-034 Reset, then read 0x04 -> PREADY high exactly on the 3rd cycle after SETUP, PRDATA=0, PSLVERR=0, irq=0.
REQ-035 Write IER=0x01 then drive gpi[0] 0->1 -> IDR bit0=1 after 2 edges, RISE=0x01 after 3, irq=1; write 0x01 to 0x08 -> RISE=0, irq=0.
REQ-036 Read 0x10 and read 0x06 -> PSLVERR=1, PRDATA=0; write 0x14 -> PSLVERR=1, IER unchanged.
REQ-037 Time gpi[1] 1->0 to set FALL bit1 in the same cycle as a W1C write of 0x02 to 0x0C -> FALL bit1 remains 1.
REQ-038 Assert reset in the ACCESS state of a write of 0xFF to IER -> IER=0 and PREADY=0 after release; the next read completes normally.
REQ-039 GPIO_WIDTH=4, write 0xFFFFFFFF to IER -> readback 0x0000000F.

Source files
------------

// File: rtl/apb_gpi_pkg.sv
// Shared definitions for the APB general-purpose-input slave: register offsets,
// transfer FSM state type and the address legality check.
package apb_gpi_pkg;

    localparam logic [7:0] IdrOffset  = 8'h00;
    localparam logic [7:0] IerOffset  = 8'h04;
    localparam logic [7:0] RiseOffset = 8'h08;
    localparam logic [7:0] FallOffset = 8'h0C;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StReady
    } apb_state_e;

    // Only word-aligned offsets inside the four-register window are decoded.
    function automatic logic addr_is_legal(input logic [7:0] addr);
        return (addr < 8'h10) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/gpi_sync_edge.sv
// Two-flop synchronizer for asynchronous input pins, plus a delay flop that
// turns the synchronized vector into single-cycle rise/fall pulses.
module gpi_sync_edge
    import apb_gpi_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] gpi_i,
    output logic [Width-1:0] sync_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;
    logic [Width-1:0] dly_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
            dly_q  <= '0;
        end else begin
            meta_q <= gpi_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~dly_q;
    assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/apb_gpi_slave.sv
// APB slave exposing synchronized input pins, an interrupt enable mask and
// sticky W1C rising/falling edge status, with one wait state per transfer.
module apb_gpi_slave
    import apb_gpi_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [7:0]            PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [GPIO_WIDTH-1:0] gpi,
    output logic                  irq
);

    apb_state_e state_q, state_d;

    logic [7:0]            addr_q, addr_d;
    logic                  write_q, write_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [GPIO_WIDTH-1:0] ier_q, ier_d;
    logic [GPIO_WIDTH-1:0] rise_q, rise_d;
    logic [GPIO_WIDTH-1:0] fall_q, fall_d;

    logic [GPIO_WIDTH-1:0] gpi_sync;
    logic [GPIO_WIDTH-1:0] rise_evt;
    logic [GPIO_WIDTH-1:0] fall_evt;
    logic [GPIO_WIDTH-1:0] rise_clr;
    logic [GPIO_WIDTH-1:0] fall_clr;
    logic [31:0]           read_word;
    logic                  wr_commit;

    // Upper write-data bits beyond the pin count are intentionally dropped.
    logic unused_wdata;
    assign unused_wdata = ^wdata_q;

    gpi_sync_edge #(
        .Width (GPIO_WIDTH)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .gpi_i  (gpi),
        .sync_o (gpi_sync),
        .rise_o (rise_evt),
        .fall_o (fall_evt)
    );

    always_comb begin
        read_word = '0;
        case (addr_q)
            IdrOffset:  read_word[GPIO_WIDTH-1:0] = gpi_sync;
            IerOffset:  read_word[GPIO_WIDTH-1:0] = ier_q;
            RiseOffset: read_word[GPIO_WIDTH-1:0] = rise_q;
            FallOffset: read_word[GPIO_WIDTH-1:0] = fall_q;
            default:    read_word = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (!PSEL) begin
                    state_d = StIdle;
                end else begin
                    err_d   = !addr_is_legal(addr_q);
                    rdata_d = (addr_is_legal(addr_q) && !write_q) ? read_word : '0;
                    state_d = StReady;
                end
            end
            StReady: begin
                // Response registers only carry meaning while PREADY is high.
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_commit = (state_q == StReady) && write_q && !err_q;
        ier_d     = ier_q;
        rise_clr  = '0;
        fall_clr  = '0;
        if (wr_commit) begin
            case (addr_q)
                IerOffset:  ier_d    = wdata_q[GPIO_WIDTH-1:0];
                RiseOffset: rise_clr = wdata_q[GPIO_WIDTH-1:0];
                FallOffset: fall_clr = wdata_q[GPIO_WIDTH-1:0];
                default:    ier_d    = ier_q;
            endcase
        end
        // A fresh edge outranks a simultaneous W1C clear of the same bit.
        rise_d = (rise_q & ~rise_clr) | rise_evt;
        fall_d = (fall_q & ~fall_clr) | fall_evt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ier_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ier_q   <= ier_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign PREADY  = (state_q == StReady);
    assign PRDATA  = rdata_q;
    assign PSLVERR = err_q;
    assign irq     = |((rise_q | fall_q) & ier_q);

endmodule

// File: tb/tb_apb_gpi_slave.sv
// Directed bench for apb_gpi_slave: an 8-pin instance for the main behaviour
// and a 4-pin instance for the narrow-width register masking.
module tb_apb_gpi_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel, psel4, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata, prdata4;
    logic        pready, pready4, pslverr, pslverr4, irq, irq4;
    logic [7:0]  gpi;
    logic [3:0]  gpi4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_gpi_slave #(
        .GPIO_WIDTH (8)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .PSEL    (psel),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr),
        .PWDATA  (pwdata),
        .PRDATA  (prdata),
        .PREADY  (pready),
        .PSLVERR (pslverr),
        .gpi     (gpi),
        .irq     (irq)
    );

    apb_gpi_slave #(
        .GPIO_WIDTH (4)
    ) u_dut4 (
        .clk     (clk),
        .reset   (reset),
        .PSEL    (psel4),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr),
        .PWDATA  (pwdata),
        .PRDATA  (prdata4),
        .PREADY  (pready4),
        .PSLVERR (pslverr4),
        .gpi     (gpi4),
        .irq     (irq4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one transfer starting just after a rising edge; n is the cycle
    // (counting SETUP as 1) in which PREADY was seen, or 0 on timeout.
    task automatic apb(input logic sel4, input logic wr, input logic [7:0] addr,
                       input logic [31:0] data, output logic [31:0] rdata,
                       output logic err, output int n);
        bit got = 1'b0;
        rdata   = '0;
        err     = 1'b0;
        n       = 0;
        psel    = !sel4;
        psel4   = sel4;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 2; i <= 8 && !got; i++) begin
            @(negedge clk);
            if ((sel4 ? pready4 : pready) === 1'b1) begin
                got   = 1'b1;
                n     = i;
                rdata = sel4 ? prdata4 : prdata;
                err   = sel4 ? pslverr4 : pslverr;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        psel    = 1'b0;
        psel4   = 1'b0;
        penable = 1'b0;
    endtask

    task automatic rd_chk(input logic sel4, input logic [7:0] addr, input logic [31:0] exp_data,
                          input logic exp_err, input string tag);
        logic [31:0] d;
        logic        e;
        int          n;
        apb(sel4, 1'b0, addr, 32'h0, d, e, n);
        chk({tag, "_wait"}, 32'(n), 32'd3);
        chk({tag, "_data"}, d, exp_data);
        chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    endtask

    task automatic wr_chk(input logic sel4, input logic [7:0] addr, input logic [31:0] data,
                          input logic exp_err, input string tag);
        logic [31:0] d;
        logic        e;
        int          n;
        apb(sel4, 1'b1, addr, data, d, e, n);
        chk({tag, "_wait"}, 32'(n), 32'd3);
        chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    endtask

    initial begin
        reset   = 1'b0;
        psel    = 1'b0;
        psel4   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        gpi     = '0;
        gpi4    = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pready", {31'b0, pready}, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pslverr", {31'b0, pslverr}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_pready4", {31'b0, pready4}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        rd_chk(1'b0, 8'h04, 32'h0, 1'b0, "ier_after_reset");
        chk("irq_after_reset", {31'b0, irq}, 32'd0);
        rd_chk(1'b0, 8'h00, 32'h0, 1'b0, "idr_quiet");
        wr_chk(1'b0, 8'h04, 32'h1, 1'b0, "ier_wr1");
        rd_chk(1'b0, 8'h04, 32'h1, 1'b0, "ier_rd1");

        // Pin 0 rises just after an edge: status lands on the 3rd edge.
        gpi = 8'h01;
        repeat (3) @(negedge clk);
        chk("irq_before_3rd_edge", {31'b0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_after_3rd_edge", {31'b0, irq}, 32'd1);
        @(posedge clk); #1;
        rd_chk(1'b0, 8'h00, 32'h01, 1'b0, "idr_pin0");
        rd_chk(1'b0, 8'h08, 32'h01, 1'b0, "rise_pin0");
        rd_chk(1'b0, 8'h0C, 32'h00, 1'b0, "fall_none");
        wr_chk(1'b0, 8'h08, 32'h01, 1'b0, "rise_w1c");
        chk("irq_cleared", {31'b0, irq}, 32'd0);
        rd_chk(1'b0, 8'h08, 32'h00, 1'b0, "rise_cleared");

        rd_chk(1'b0, 8'h10, 32'h0, 1'b1, "rd_out_of_range");
        rd_chk(1'b0, 8'h06, 32'h0, 1'b1, "rd_misaligned");
        wr_chk(1'b0, 8'h14, 32'hFF, 1'b1, "wr_out_of_range");
        rd_chk(1'b0, 8'h04, 32'h1, 1'b0, "ier_kept");
        wr_chk(1'b0, 8'h00, 32'hFF, 1'b0, "idr_wr_ignored");
        rd_chk(1'b0, 8'h00, 32'h01, 1'b0, "idr_after_wr");

        // Pin 1 rises; IER masks it off the interrupt.
        gpi = 8'h03;
        repeat (4) @(posedge clk);
        #1;
        rd_chk(1'b0, 8'h08, 32'h02, 1'b0, "rise_pin1");
        chk("irq_masked", {31'b0, irq}, 32'd0);
        wr_chk(1'b0, 8'h08, 32'h00, 1'b0, "rise_w0");
        rd_chk(1'b0, 8'h08, 32'h02, 1'b0, "rise_w0_kept");

        // Pin 1 falls so that its status sets on the same edge the W1C commits.
        gpi = 8'h01;
        wr_chk(1'b0, 8'h0C, 32'h02, 1'b0, "fall_race_wr");
        rd_chk(1'b0, 8'h0C, 32'h02, 1'b0, "fall_set_wins");
        wr_chk(1'b0, 8'h0C, 32'h02, 1'b0, "fall_w1c");
        rd_chk(1'b0, 8'h0C, 32'h00, 1'b0, "fall_cleared");
        wr_chk(1'b0, 8'h08, 32'h02, 1'b0, "rise1_w1c");
        rd_chk(1'b0, 8'h08, 32'h00, 1'b0, "rise1_cleared");

        // Reset lands in the ACCESS phase of an IER write.
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h04;
        pwdata  = 32'hFF;
        @(posedge clk); #1;
        penable = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("abort_pready", {31'b0, pready}, 32'd0);
        chk("abort_irq", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        rd_chk(1'b0, 8'h04, 32'h0, 1'b0, "ier_after_abort");
        repeat (4) @(posedge clk);
        #1;
        // Pin 0 stayed high through reset, so it reappears as a rising edge.
        rd_chk(1'b0, 8'h08, 32'h01, 1'b0, "rise_after_release");
        rd_chk(1'b0, 8'h0C, 32'h00, 1'b0, "fall_after_release");

        wr_chk(1'b1, 8'h04, 32'hFFFF_FFFF, 1'b0, "w4_ier_wr");
        rd_chk(1'b1, 8'h04, 32'h0000_000F, 1'b0, "w4_ier_rd");
        rd_chk(1'b1, 8'h08, 32'h0, 1'b0, "w4_rise");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
